// File: rtl/esc_frame_sched.sv
// Frame scheduler and arming controller for four ESC pulse generators.
// Issues a frame-start wrt strobe and refreshes clamped, slew-limited speeds
// once per frame while sequencing disarmed/arming/armed/failsafe.
module esc_frame_sched #(
    parameter int unsigned PERIOD         = 1_000_000,
    parameter int unsigned ARM_FRAMES     = 50,
    parameter int unsigned TIMEOUT_FRAMES = 5,
    parameter int unsigned MAX_SPD        = 1900,
    parameter int unsigned SLEW           = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic        spd_vld,
    input  logic [10:0] frnt_cmd,
    input  logic [10:0] bck_cmd,
    input  logic [10:0] lft_cmd,
    input  logic [10:0] rght_cmd,
    output logic        wrt,
    output logic [10:0] frnt_spd,
    output logic [10:0] bck_spd,
    output logic [10:0] lft_spd,
    output logic [10:0] rght_spd,
    output logic        armed,
    output logic        failsafe
);

    localparam int unsigned SPD_W = 11;
    localparam int unsigned N_MOT = 4;
    localparam int unsigned FRM_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned ARM_W = $clog2(ARM_FRAMES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(PERIOD - 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_FRAMES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_FRAMES - 1);
    localparam logic [SPD_W-1:0] MAX_C    = SPD_W'(MAX_SPD);
    localparam logic [SPD_W-1:0] SLEW_C   = SPD_W'(SLEW);

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMING   = 2'd1,
        S_ARMED    = 2'd2,
        S_FAILSAFE = 2'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [FRM_W-1:0]              r_frame_cnt;
    logic                          w_wrap;
    logic [ARM_W-1:0]              r_arm_cnt;
    logic [ARM_W-1:0]              w_arm_cnt_nxt;
    logic [TO_W-1:0]               r_to_cnt;
    logic [TO_W-1:0]               w_to_cnt_nxt;
    logic [N_MOT-1:0][SPD_W-1:0]   w_cmd_in;
    logic [N_MOT-1:0][SPD_W-1:0]   r_cmd;
    logic [N_MOT-1:0][SPD_W-1:0]   w_cmd;
    logic [N_MOT-1:0][SPD_W-1:0]   r_spd;
    logic [N_MOT-1:0][SPD_W-1:0]   w_spd_nxt;
    logic                          w_load_slew;
    logic                          r_wrt;
    logic                          r_armed;
    logic                          r_failsafe;

    // Clamp to MAX_SPD, then rise by at most SLEW; decreases apply immediately.
    function automatic logic [SPD_W-1:0] f_slew(input logic [SPD_W-1:0] cur,
                                                 input logic [SPD_W-1:0] cmd);
        logic [SPD_W-1:0] tgt;
        logic [SPD_W-1:0] diff;
        tgt = (cmd > MAX_C) ? MAX_C : cmd;
        if (tgt > cur) begin
            diff   = tgt - cur;
            f_slew = (diff > SLEW_C) ? (cur + SLEW_C) : tgt;
        end else begin
            f_slew = tgt;
        end
    endfunction

    assign w_cmd_in = {rght_cmd, lft_cmd, bck_cmd, frnt_cmd};
    assign w_wrap   = (r_frame_cnt == FRM_LAST);

    // A strobe coinciding with a frame update feeds that update directly.
    always_comb begin
        w_cmd = spd_vld ? w_cmd_in : r_cmd;
    end

    // Frame counter: 0..PERIOD-1, wrap edge drives the frame refresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_wrap) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= r_frame_cnt + FRM_W'(1);
        end
    end

    // FSM state and frame-based counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_DISARMED;
            r_arm_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arm_cnt <= w_arm_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
        end
    end

    // Next-state logic; disarm overrides everything, fresh commands beat timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_arm_cnt_nxt = r_arm_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        if (!arm) begin
            w_state_nxt   = S_DISARMED;
            w_arm_cnt_nxt = '0;
            w_to_cnt_nxt  = '0;
        end else begin
            case (r_state)
                S_DISARMED: begin
                    w_state_nxt   = S_ARMING;
                    w_arm_cnt_nxt = '0;
                end
                S_ARMING: begin
                    if (w_wrap) begin
                        if (r_arm_cnt == ARM_LAST) begin
                            w_state_nxt   = S_ARMED;
                            w_arm_cnt_nxt = '0;
                            w_to_cnt_nxt  = '0;
                        end else begin
                            w_arm_cnt_nxt = r_arm_cnt + ARM_W'(1);
                        end
                    end
                end
                S_ARMED: begin
                    if (spd_vld) begin
                        w_to_cnt_nxt = '0;
                    end else if (w_wrap) begin
                        if (r_to_cnt == TO_LAST) begin
                            w_state_nxt  = S_FAILSAFE;
                            w_to_cnt_nxt = '0;
                        end else begin
                            w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_FAILSAFE;
                end
            endcase
        end
    end

    // Speeds track commands only while remaining armed across the wrap; else zero.
    always_comb begin
        w_load_slew = (r_state == S_ARMED) && (w_state_nxt == S_ARMED);
        for (int i = 0; i < int'(N_MOT); i++) begin
            w_spd_nxt[i] = w_load_slew ? f_slew(r_spd[i], w_cmd[i]) : '0;
        end
    end

    // Command latch, frame-synchronous speed load, and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd      <= '0;
            r_spd      <= '0;
            r_wrt      <= 1'b0;
            r_armed    <= 1'b0;
            r_failsafe <= 1'b0;
        end else begin
            if (spd_vld) begin
                r_cmd <= w_cmd_in;
            end
            if (w_wrap) begin
                r_spd <= w_spd_nxt;
            end
            r_wrt      <= w_wrap;
            r_armed    <= (w_state_nxt == S_ARMED);
            r_failsafe <= (w_state_nxt == S_FAILSAFE);
        end
    end

    assign wrt      = r_wrt;
    assign frnt_spd = r_spd[0];
    assign bck_spd  = r_spd[1];
    assign lft_spd  = r_spd[2];
    assign rght_spd = r_spd[3];
    assign armed    = r_armed;
    assign failsafe = r_failsafe;

endmodule

// File: tb/tb_esc_frame_sched.sv
// Self-checking bench for esc_frame_sched: cycle model plus directed scenarios.
module tb_esc_frame_sched;

    localparam int PERIOD  = 100;
    localparam int ARM_FR  = 3;
    localparam int TO_FR   = 5;
    localparam int MAXS    = 1800;
    localparam int SLEWV   = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm;
    logic        spd_vld;
    logic [10:0] frnt_cmd, bck_cmd, lft_cmd, rght_cmd;
    logic        wrt;
    logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
    logic        armed, failsafe;

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;
    int last_gap = 0;

    esc_frame_sched #(
        .PERIOD(PERIOD), .ARM_FRAMES(ARM_FR), .TIMEOUT_FRAMES(TO_FR),
        .MAX_SPD(MAXS), .SLEW(SLEWV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .spd_vld(spd_vld),
        .frnt_cmd(frnt_cmd), .bck_cmd(bck_cmd), .lft_cmd(lft_cmd), .rght_cmd(rght_cmd),
        .wrt(wrt), .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd),
        .rght_spd(rght_spd), .armed(armed), .failsafe(failsafe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 off, 1 arming, 2 armed, 3 failsafe.
    int m_pos = 0, m_mode = 0, m_arm_wraps = 0, m_quiet = 0;
    int m_cmd[4] = '{0, 0, 0, 0};
    int m_spd[4] = '{0, 0, 0, 0};
    int m_in[4];
    int m_use[4];
    int m_new;
    bit m_wrap;
    bit m_wrt = 1'b0, m_armed = 1'b0, m_fs = 1'b0;

    function automatic int next_speed(input int cur, input int cmd);
        int tgt;
        tgt = (cmd < MAXS) ? cmd : MAXS;
        if (tgt > cur) return (cur + SLEWV < tgt) ? cur + SLEWV : tgt;
        return tgt;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pos = 0; m_mode = 0; m_arm_wraps = 0; m_quiet = 0;
            for (int i = 0; i < 4; i++) begin m_cmd[i] = 0; m_spd[i] = 0; end
            m_wrt = 0; m_armed = 0; m_fs = 0;
        end else begin
            m_wrap = (m_pos == PERIOD - 1);
            m_in[0] = int'(frnt_cmd); m_in[1] = int'(bck_cmd);
            m_in[2] = int'(lft_cmd);  m_in[3] = int'(rght_cmd);
            for (int i = 0; i < 4; i++) m_use[i] = spd_vld ? m_in[i] : m_cmd[i];
            m_new = m_mode;
            if (!arm) begin
                m_new = 0; m_arm_wraps = 0; m_quiet = 0;
            end else if (m_mode == 0) begin
                m_new = 1; m_arm_wraps = 0;
            end else if (m_mode == 1) begin
                if (m_wrap) m_arm_wraps++;
                if (m_arm_wraps == ARM_FR) begin m_new = 2; m_quiet = 0; end
            end else if (m_mode == 2) begin
                if (spd_vld) m_quiet = 0;
                else if (m_wrap) m_quiet++;
                if (m_quiet == TO_FR) m_new = 3;
            end
            if (m_wrap)
                for (int i = 0; i < 4; i++)
                    m_spd[i] = (m_mode == 2 && m_new == 2) ? next_speed(m_spd[i], m_use[i]) : 0;
            if (spd_vld) for (int i = 0; i < 4; i++) m_cmd[i] = m_in[i];
            m_wrt   = m_wrap;
            m_pos   = m_wrap ? 0 : m_pos + 1;
            m_mode  = m_new;
            m_armed = (m_new == 2);
            m_fs    = (m_new == 3);
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (!done) begin
            chk("m_wrt", int'(wrt), int'(m_wrt));
            chk("m_frnt", int'(frnt_spd), m_spd[0]);
            chk("m_bck", int'(bck_spd), m_spd[1]);
            chk("m_lft", int'(lft_spd), m_spd[2]);
            chk("m_rght", int'(rght_spd), m_spd[3]);
            chk("m_armed", int'(armed), int'(m_armed));
            chk("m_failsafe", int'(failsafe), int'(m_fs));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_wrt();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wrt && n < 2 * PERIOD);
        last_gap = n;
        chk("wrt_seen", int'(wrt), 1);
    endtask

    task automatic set_cmd(input int f, input int b, input int l, input int r);
        frnt_cmd = 11'(f); bck_cmd = 11'(b); lft_cmd = 11'(l); rght_cmd = 11'(r);
    endtask

    // One frame with a mid-frame command strobe, ending at the next wrt.
    task automatic frame_vld(input int f, input int b, input int l, input int r);
        step(10);
        set_cmd(f, b, l, r);
        spd_vld = 1'b1;
        step(1);
        spd_vld = 1'b0;
        wait_wrt();
    endtask

    task automatic first_wrt_after_release(input string name);
        int first = 0;
        for (int k = 1; k <= PERIOD + 2; k++) begin
            @(negedge clk);
            if (wrt && first == 0) first = k;
        end
        chk(name, first, PERIOD);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n = 1'b0; arm = 1'b0; spd_vld = 1'b0;
        set_cmd(0, 0, 0, 0);
        step(3);
        chk("rst_wrt", int'(wrt), 0);
        chk("rst_frnt", int'(frnt_spd), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_failsafe", int'(failsafe), 0);
        #2 rst_n = 1'b1;

        // 1: disarmed frames
        first_wrt_after_release("first_wrt");
        wait_wrt();
        wait_wrt();
        chk("wrt_period", last_gap, PERIOD);
        chk("dis_frnt", int'(frnt_spd), 0);

        // 2: arming then timeout
        step(10);
        arm = 1'b1;
        wait_wrt(); chk("arming_w1", int'(armed), 0);
        wait_wrt(); chk("arming_w2", int'(armed), 0);
        wait_wrt(); chk("armed_w3", int'(armed), 1);
        chk("armed_w3_spd", int'(frnt_spd), 0);
        for (int n = 1; n <= 4; n++) begin
            wait_wrt(); chk("no_fs_yet", int'(failsafe), 0);
        end
        wait_wrt();
        chk("fs_after_5", int'(failsafe), 1);
        chk("fs_not_armed", int'(armed), 0);
        arm = 1'b0;
        step(1);
        chk("fs_cleared", int'(failsafe), 0);

        // 3: ramp to 500 then immediate drop to 100
        arm = 1'b1;
        repeat (3) wait_wrt();
        chk("rearmed", int'(armed), 1);
        for (int n = 1; n <= 8; n++) begin
            frame_vld(500, 0, 30, 1000);
            chk("ramp500", int'(frnt_spd), (n < 8) ? 64 * n : 500);
        end
        chk("lft_small", int'(lft_spd), 30);
        frame_vld(100, 0, 30, 1000);
        chk("drop100", int'(frnt_spd), 100);

        // 4: over-range command clamps at MAX_SPD
        frame_vld(2000, 2000, 2000, 2000);
        chk("ramp164", int'(frnt_spd), 164);
        repeat (29) frame_vld(2000, 2000, 2000, 2000);
        chk("clamp_frnt", int'(frnt_spd), 1800);
        chk("clamp_bck", int'(bck_spd), 1800);
        chk("clamp_lft", int'(lft_spd), 1800);
        chk("clamp_rght", int'(rght_spd), 1800);

        // 5: command loss -> failsafe, sticky until disarm
        repeat (3) begin
            wait_wrt();
            chk("hold1800", int'(frnt_spd), 1800);
            chk("hold_nofs", int'(failsafe), 0);
        end
        wait_wrt();
        chk("fs_loss", int'(failsafe), 1);
        chk("fs_zero", int'(frnt_spd), 0);
        frame_vld(500, 500, 500, 500);
        chk("fs_sticky", int'(failsafe), 1);
        chk("fs_sticky_spd", int'(frnt_spd), 0);
        arm = 1'b0;
        step(1);
        chk("fs_exit", int'(failsafe), 0);

        // 6a: disarm mid-ramp
        arm = 1'b1;
        repeat (3) wait_wrt();
        repeat (3) frame_vld(1000, 0, 0, 0);
        chk("ramp192", int'(frnt_spd), 192);
        step(20);
        arm = 1'b0;
        step(1);
        chk("disarm_now", int'(armed), 0);
        wait_wrt();
        chk("disarm_zero", int'(frnt_spd), 0);

        // 6b: reset asserted during a wrt cycle
        arm = 1'b1;
        repeat (3) wait_wrt();
        repeat (2) frame_vld(1000, 0, 0, 0);
        chk("pre_rst_spd", int'(frnt_spd), 128);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_wrt", int'(wrt), 0);
        chk("rst_mid_spd", int'(frnt_spd), 0);
        chk("rst_mid_armed", int'(armed), 0);
        arm = 1'b0;
        step(2);
        #2 rst_n = 1'b1;
        first_wrt_after_release("first_wrt_rst");

        // 6c: strobe on the expiry clock keeps ARMED and feeds that update
        arm = 1'b1;
        repeat (3) wait_wrt();
        chk("armed_c", int'(armed), 1);
        repeat (4) wait_wrt();
        step(PERIOD - 1);
        set_cmd(300, 0, 0, 0);
        spd_vld = 1'b1;
        step(1);
        spd_vld = 1'b0;
        chk("exp_wrt", int'(wrt), 1);
        chk("exp_nofs", int'(failsafe), 0);
        chk("exp_armed", int'(armed), 1);
        chk("exp_spd", int'(frnt_spd), 64);

        // 6d: arm falls exactly on the wrap edge
        step(PERIOD - 1);
        arm = 1'b0;
        step(1);
        chk("fall_wrt", int'(wrt), 1);
        chk("fall_zero", int'(frnt_spd), 0);
        chk("fall_armed", int'(armed), 0);

        step(5);
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute backstop against a stalled run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
